saph_plr_hs: RTL and testbench

- Parametrised elastic pipeline-register chain with a valid/ready handshake, per-stage valid bits, a flush, and an optional bubble-collapsing mode.
- Successor to the plain fixed-latency register chain, for datapaths that must stall under backpressure without losing or duplicating data.
- Sits between GPU pipeline stages: shader issue to ALU, and ALU to writeback.

---
 rtl/saph_pkg.sv | 13 +
 rtl/saph_plr_hs_stage.sv | 44 ++++
 rtl/saph_plr_hs.sv | 110 +++++++++++
 tb/tb_saph_plr_hs.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/saph_pkg.sv
// Shared definitions for the saph pipeline-register family: mode selectors
// and the occupancy-counter width helper.
package saph_pkg;

  localparam int unsigned SAPH_PLR_LOCKSTEP = 0;
  localparam int unsigned SAPH_PLR_COLLAPSE = 1;

  // A zero-stage chain still exposes a 1-bit occupancy port.
  function automatic int unsigned saph_occ_width(input int unsigned lat);
    return (lat == 0) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/saph_plr_hs_stage.sv
// One elastic pipeline stage: a valid bit and a data register that load from
// the previous stage when adv is high. Flush clears only the valid bit.
module saph_plr_hs_stage #(
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic             prev_valid,
  input  logic [width-1:0] prev_data,
  output logic             valid,
  output logic [width-1:0] data
);

  logic             valid_q, valid_d;
  logic [width-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv) begin
      valid_d = prev_valid;
      data_d  = prev_data;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/saph_plr_hs.sv
// Elastic valid/ready register chain with flush, occupancy count and either
// bubble-collapsing or lockstep advance; latency=0 is a wire pass-through.
module saph_plr_hs
  import saph_pkg::*;
#(
  parameter int unsigned width    = 1,
  parameter int unsigned latency  = 1,
  parameter int unsigned collapse = SAPH_PLR_COLLAPSE
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  d_valid,
  output logic                                  d_ready,
  input  logic [width-1:0]                      d,
  output logic                                  q_valid,
  input  logic                                  q_ready,
  output logic [width-1:0]                      q,
  output logic [saph_occ_width(latency)-1:0]    occupancy
);

  localparam int unsigned OW = saph_occ_width(latency);

  generate
    if (latency == 0) begin : g_bypass
      logic unused_inputs;

      assign q         = d;
      assign q_valid   = d_valid;
      assign d_ready   = q_ready;
      assign occupancy = '0;
      assign unused_inputs = ^{clk, rst, flush};
    end else begin : g_pipe
      logic [latency-1:0] v;
      logic [width-1:0]   r [latency];
      logic [latency-1:0] adv;
      logic               in_xfer;
      logic               out_xfer;
      logic [OW-1:0]      occ_q, occ_d;

      // Collapse: each stage advances if empty or its successor advances,
      // giving a combinational ready chain from q_ready back to d_ready.
      always_comb begin
        adv = '0;
        if (collapse == SAPH_PLR_COLLAPSE) begin
          adv[latency-1] = !v[latency-1] || q_ready;
          for (int unsigned k = 1; k < latency; k++) begin
            adv[latency-1-k] = !v[latency-1-k] || adv[latency-k];
          end
        end else begin
          adv = {latency{!v[latency-1] || q_ready}};
        end
      end

      for (genvar i = 0; i < latency; i++) begin : g_stage
        logic             prev_valid;
        logic [width-1:0] prev_data;

        if (i == 0) begin : g_first
          assign prev_valid = d_valid;
          assign prev_data  = d;
        end else begin : g_next
          assign prev_valid = v[i-1];
          assign prev_data  = r[i-1];
        end

        saph_plr_hs_stage #(
          .width(width)
        ) u_stage (
          .clk       (clk),
          .rst       (rst),
          .flush     (flush),
          .adv       (adv[i]),
          .prev_valid(prev_valid),
          .prev_data (prev_data),
          .valid     (v[i]),
          .data      (r[i])
        );
      end

      assign d_ready  = adv[0];
      assign q_valid  = v[latency-1];
      assign q        = r[latency-1];
      assign in_xfer  = d_valid && adv[0];
      assign out_xfer = v[latency-1] && q_ready;

      always_comb begin
        occ_d = occ_q;
        if (flush) begin
          occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
          occ_d = occ_q + OW'(1);
        end else if (!in_xfer && out_xfer) begin
          occ_d = occ_q - OW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          occ_q <= '0;
        end else begin
          occ_q <= occ_d;
        end
      end

      assign occupancy = occ_q;
    end
  endgenerate

endmodule

// File: tb/tb_saph_plr_hs.sv
// Bench for saph_plr_hs: collapse, lockstep and pass-through instances with
// per-instance scoreboards checked on the falling clock edge.
module tb_saph_plr_hs;
  import saph_pkg::*;

  localparam int unsigned W = 8;

  logic clk, rst, flush;

  logic         dv_a, dr_a, qv_a, qr_a;
  logic [W-1:0] d_a, q_a;
  logic [1:0]   occ_a;

  logic         dv_b, dr_b, qv_b, qr_b;
  logic [W-1:0] d_b, q_b;
  logic [1:0]   occ_b;

  logic         dv_c, dr_c, qv_c, qr_c;
  logic [W-1:0] d_c, q_c;
  logic [0:0]   occ_c;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_a [$];
  logic [W-1:0] sb_b [$];
  bit mon_en = 1'b0;

  saph_plr_hs #(.width(W), .latency(3), .collapse(SAPH_PLR_COLLAPSE)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .d_valid(dv_a), .d_ready(dr_a), .d(d_a),
    .q_valid(qv_a), .q_ready(qr_a), .q(q_a), .occupancy(occ_a)
  );

  saph_plr_hs #(.width(W), .latency(3), .collapse(SAPH_PLR_LOCKSTEP)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .d_valid(dv_b), .d_ready(dr_b), .d(d_b),
    .q_valid(qv_b), .q_ready(qr_b), .q(q_b), .occupancy(occ_b)
  );

  saph_plr_hs #(.width(W), .latency(0), .collapse(SAPH_PLR_COLLAPSE)) u_dut_c (
    .clk(clk), .rst(rst), .flush(flush), .d_valid(dv_c), .d_ready(dr_c), .d(d_c),
    .q_valid(qv_c), .q_ready(qr_c), .q(q_c), .occupancy(occ_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Occupancy must equal the number of words in flight (scoreboard depth).
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("a_occ", 32'(occ_a), 32'(sb_a.size()));
      if (!rst && qv_a && qr_a) begin
        if (sb_a.size() == 0) check_eq("a_q_unexpected", 32'(qv_a), 32'd0);
        else check_eq("a_q_order", 32'(q_a), 32'(sb_a.pop_front()));
      end
      if (rst || flush) sb_a.delete();
      else if (dv_a && dr_a) sb_a.push_back(d_a);

      check_eq("b_occ", 32'(occ_b), 32'(sb_b.size()));
      if (!rst && qv_b && qr_b) begin
        if (sb_b.size() == 0) check_eq("b_q_unexpected", 32'(qv_b), 32'd0);
        else check_eq("b_q_order", 32'(q_b), 32'(sb_b.pop_front()));
      end
      if (rst || flush) sb_b.delete();
      else if (dv_b && dr_b) sb_b.push_back(d_b);
    end
  end

  task automatic drain_a(input int budget);
    qr_a = 1'b1;
    dv_a = 1'b0;
    for (int i = 0; i < budget && (qv_a || occ_a != 0); i++) step();
    check_eq("a_drain_occ", 32'(occ_a), 32'd0);
    check_eq("a_drain_qv", 32'(qv_a), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    dv_a = 1'b0; qr_a = 1'b1; d_a = '0;
    dv_b = 1'b0; qr_b = 1'b1; d_b = '0;
    dv_c = 1'b0; qr_c = 1'b0; d_c = '0;
    step();
    step();
    check_eq("a_rst_qv", 32'(qv_a), 32'd0);
    check_eq("a_rst_q", 32'(q_a), 32'd0);
    check_eq("a_rst_occ", 32'(occ_a), 32'd0);
    check_eq("a_rst_rdy", 32'(dr_a), 32'd1);
    check_eq("b_rst_qv", 32'(qv_b), 32'd0);
    check_eq("b_rst_occ", 32'(occ_b), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Streaming 0x01..0x10 back to back, consumer always ready.
    for (int i = 0; i < 16; i++) begin
      dv_a = 1'b1;
      d_a  = W'(i + 1);
      #1;
      check_eq("a_stream_rdy", 32'(dr_a), 32'd1);
      step();
      if (i < 2) begin
        check_eq("a_stream_early_qv", 32'(qv_a), 32'd0);
      end else begin
        check_eq("a_stream_qv", 32'(qv_a), 32'd1);
        check_eq("a_stream_q", 32'(q_a), 32'(i - 1));
        check_eq("a_stream_occ", 32'(occ_a), 32'd3);
      end
    end
    drain_a(10);

    // Backpressure fill: three accepts then d_ready drops.
    qr_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dv_a = 1'b1;
      d_a  = W'(8'hA0 + i);
      #1;
      check_eq("a_bp_rdy", 32'(dr_a), 32'd1);
      step();
    end
    d_a = 8'hA3;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("a_bp_full_rdy", 32'(dr_a), 32'd0);
      check_eq("a_bp_hold_qv", 32'(qv_a), 32'd1);
      check_eq("a_bp_hold_q", 32'(q_a), 32'hA0);
      check_eq("a_bp_occ", 32'(occ_a), 32'd3);
      step();
    end
    qr_a = 1'b1;
    #1;
    check_eq("a_bp_release_rdy", 32'(dr_a), 32'd1);
    step();
    drain_a(10);

    // Lockstep: bubble between 0x11 and 0x22 must survive a stall.
    qr_b = 1'b1;
    dv_b = 1'b1; d_b = 8'h11; step();
    dv_b = 1'b0; step();
    dv_b = 1'b1; d_b = 8'h22; step();
    dv_b = 1'b0;
    check_eq("b_first_qv", 32'(qv_b), 32'd1);
    check_eq("b_first_q", 32'(q_b), 32'h11);
    qr_b = 1'b0;
    #1;
    check_eq("b_stall_rdy", 32'(dr_b), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("b_stall_qv", 32'(qv_b), 32'd1);
      check_eq("b_stall_q", 32'(q_b), 32'h11);
      check_eq("b_stall_occ", 32'(occ_b), 32'd2);
    end
    qr_b = 1'b1;
    #1;
    check_eq("b_release_rdy", 32'(dr_b), 32'd1);
    step();
    check_eq("b_bubble_qv", 32'(qv_b), 32'd0);
    step();
    check_eq("b_second_qv", 32'(qv_b), 32'd1);
    check_eq("b_second_q", 32'(q_b), 32'h22);
    step();
    check_eq("b_empty_qv", 32'(qv_b), 32'd0);
    check_eq("b_empty_occ", 32'(occ_b), 32'd0);

    // Flush with an output transfer and an input offer in the same cycle.
    qr_a = 1'b0;
    dv_a = 1'b1; d_a = 8'hB0; step();
    d_a = 8'hB1; step();
    dv_a = 1'b0; step();
    check_eq("a_fl_pre_qv", 32'(qv_a), 32'd1);
    check_eq("a_fl_pre_q", 32'(q_a), 32'hB0);
    flush = 1'b1; qr_a = 1'b1; dv_a = 1'b1; d_a = 8'h55;
    #1;
    check_eq("a_fl_rdy", 32'(dr_a), 32'd1);
    step();
    flush = 1'b0; dv_a = 1'b0;
    check_eq("a_fl_qv", 32'(qv_a), 32'd0);
    check_eq("a_fl_occ", 32'(occ_a), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("a_fl_empty_qv", 32'(qv_a), 32'd0);
    end

    // Reset on a full, stalled pipe together with flush and an input offer.
    qr_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dv_a = 1'b1;
      d_a  = W'(8'hC0 + i);
      step();
    end
    dv_a = 1'b0;
    check_eq("a_rs_full_rdy", 32'(dr_a), 32'd0);
    rst = 1'b1; flush = 1'b1; dv_a = 1'b1; d_a = 8'h77;
    step();
    rst = 1'b0; flush = 1'b0; dv_a = 1'b0;
    check_eq("a_rs_qv", 32'(qv_a), 32'd0);
    check_eq("a_rs_q", 32'(q_a), 32'd0);
    check_eq("a_rs_occ", 32'(occ_a), 32'd0);
    check_eq("a_rs_rdy", 32'(dr_a), 32'd1);
    qr_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("a_rs_empty_qv", 32'(qv_a), 32'd0);
    end

    // Pass-through: pure wires, flush must not matter.
    for (int i = 0; i < 24; i++) begin
      d_c   = W'($urandom_range(0, 255));
      dv_c  = 1'($urandom_range(0, 1));
      qr_c  = 1'($urandom_range(0, 1));
      flush = (i == 10);
      #1;
      check_eq("c_q", 32'(q_c), 32'(d_c));
      check_eq("c_qv", 32'(qv_c), 32'(dv_c));
      check_eq("c_rdy", 32'(dr_c), 32'(qr_c));
      check_eq("c_occ", 32'(occ_c), 32'd0);
      step();
    end
    flush  = 1'b0;
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
